// File: rtl/data_memory.sv
// Single-port-write / registered-read data memory with a hardware zero-fill sweep after reset.
// Optional same-address write-to-read forwarding is enabled by defining DATA_MEM_FWD_EN.
`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 16
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 4
`endif

module data_memory #(
    parameter int word_size = `DATA_WORD_SIZE,
    parameter int addr_size = `DATA_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 w_en,
    input  logic [addr_size-1:0] w_addr,
    input  logic [word_size-1:0] d_in,
    input  logic                 r_en,
    input  logic [addr_size-1:0] r_addr,
    output logic [word_size-1:0] d_out,
    output logic                 r_valid
);
    localparam int depth = 2 ** addr_size;
    localparam logic [addr_size:0] last_addr = (addr_size + 1)'(depth - 1);
    localparam logic [addr_size:0] ptr_one   = (addr_size + 1)'(1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t               state, state_nxt;
    logic [addr_size:0]   clr_ptr, clr_ptr_nxt;
    logic                 mem_we;
    logic [addr_size-1:0] mem_waddr;
    logic [word_size-1:0] mem_wdata;
    logic                 rd_fire;
    logic                 fwd_hit;

    logic [word_size-1:0] bank [depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // The sweep owns the write port while CLEAR; user ports are ignored until READY.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        mem_we      = 1'b0;
        mem_waddr   = w_addr;
        mem_wdata   = d_in;
        rd_fire     = 1'b0;
        case (state)
            CLEAR: begin
                mem_we      = ~clr_ptr[addr_size];
                mem_waddr   = clr_ptr[addr_size-1:0];
                mem_wdata   = '0;
                clr_ptr_nxt = clr_ptr + ptr_one;
                if (clr_ptr == last_addr)
                    state_nxt = READY;
            end
            READY: begin
                mem_we  = w_en;
                rd_fire = r_en;
            end
            default: state_nxt = CLEAR;
        endcase
        if (rst) begin
            mem_we  = 1'b0;
            rd_fire = 1'b0;
        end
    end

    assign ready = (state == READY);

    always_ff @(posedge clk) begin
        if (mem_we)
            bank[mem_waddr] <= mem_wdata;
    end

`ifdef DATA_MEM_FWD_EN
    assign fwd_hit = w_en && (w_addr == r_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // Without forwarding a colliding read returns the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_fire;
            if (rd_fire)
                d_out <= fwd_hit ? d_in : bank[r_addr];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory: behavioural model checked every cycle plus literal test-plan checks.
module tb_data_memory;
    localparam int WS = 16;
    localparam int AS = 4;
    localparam int DEPTH = 2 ** AS;
`ifdef DATA_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk, rst, ready, w_en, r_en, r_valid;
    logic [AS-1:0] w_addr, r_addr;
    logic [WS-1:0] d_in, d_out;

    int total = 0;
    int bad = 0;
    bit checking = 0;

    data_memory #(.word_size(WS), .addr_size(AS)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .w_en(w_en), .w_addr(w_addr), .d_in(d_in),
        .r_en(r_en), .r_addr(r_addr), .d_out(d_out), .r_valid(r_valid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory becomes all-zero the moment DEPTH uninterrupted non-reset edges have passed.
    logic [WS-1:0] m_mem [DEPTH];
    int            sweep_cnt;
    bit            m_ready, m_rvalid;
    logic [WS-1:0] m_dout;

    always @(posedge clk) begin
        if (rst) begin
            sweep_cnt <= 0;
            m_ready   <= 0;
            m_rvalid  <= 0;
            m_dout    <= '0;
        end else if (!m_ready) begin
            m_rvalid  <= 0;
            sweep_cnt <= sweep_cnt + 1;
            if (sweep_cnt + 1 == DEPTH) begin
                m_ready <= 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            end
        end else begin
            m_rvalid <= r_en;
            if (r_en) m_dout <= (FWD && w_en && w_addr == r_addr) ? d_in : m_mem[r_addr];
            if (w_en) m_mem[w_addr] <= d_in;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("ready", {31'b0, ready}, {31'b0, m_ready});
            chk("r_valid", {31'b0, r_valid}, {31'b0, m_rvalid});
            chk("d_out", {16'b0, d_out}, {16'b0, m_dout});
        end
    end

    task automatic idle();
        w_en = 0; r_en = 0;
    endtask

    task automatic do_write(input int a, input logic [WS-1:0] d);
        w_en = 1; w_addr = AS'(a); d_in = d; r_en = 0;
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input string name, input int a, input logic [WS-1:0] exp);
        r_en = 1; r_addr = AS'(a); w_en = 0;
        @(negedge clk);
        r_en = 0;
        chk({name, "_valid"}, {31'b0, r_valid}, 32'd1);
        chk(name, {16'b0, d_out}, {16'b0, exp});
    endtask

    // Counts edges until ready rises, bounded so a stuck sweep cannot hang the run.
    task automatic wait_ready(input string name);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (ready) break;
        end
        idle();
        chk(name, n, 16);
    endtask

    initial begin
        rst = 1; idle(); w_addr = '0; r_addr = '0; d_in = '0;
        @(negedge clk);
        checking = 1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_r_valid", {31'b0, r_valid}, 32'd0);
        chk("rst_d_out", {16'b0, d_out}, 32'd0);
        repeat (2) @(negedge clk);

        // Sweep with user traffic hammering the ports.
        rst = 0;
        w_en = 1; w_addr = 4'd2; d_in = 16'hAAAA; r_en = 1; r_addr = 4'd2;
        wait_ready("sweep_len");
        for (int a = 0; a < DEPTH; a++) do_read($sformatf("zero_%0d", a), a, 16'h0000);

        do_write(5, 16'hBEEF);
        do_read("wr_rd", 5, 16'hBEEF);
        @(negedge clk);
        chk("hold_valid", {31'b0, r_valid}, 32'd0);
        chk("hold_dout", {16'b0, d_out}, 32'h0000BEEF);

        do_write(3, 16'h1111);
        w_en = 1; w_addr = 4'd3; d_in = 16'h2222; r_en = 1; r_addr = 4'd3;
        @(negedge clk);
        idle();
        chk("collide", {16'b0, d_out}, FWD ? 32'h2222 : 32'h1111);
        do_read("collide_after", 3, 16'h2222);

        for (int i = 0; i < 400; i++) begin
            w_en   = ($urandom_range(0, 1) == 1);
            r_en   = ($urandom_range(0, 3) != 0);
            w_addr = AS'($urandom_range(0, 7));
            r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AS'($urandom_range(0, 7));
            d_in   = WS'($urandom);
            @(negedge clk);
        end
        idle();

        // Reset with a write landed and a read in flight, then a mid-sweep reset.
        do_write(9, 16'h1234);
        r_en = 1; r_addr = 4'd9;
        @(negedge clk);
        rst = 1; r_en = 0;
        @(negedge clk);
        chk("rst_drop_valid", {31'b0, r_valid}, 32'd0);
        rst = 0;
        repeat (7) @(negedge clk);
        chk("mid_sweep_ready", {31'b0, ready}, 32'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_ready("resweep_len");
        do_read("addr9_cleared", 9, 16'h0000);
        do_read("addr5_cleared", 5, 16'h0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
